// File: rtl/poly_pkg.sv
// Shared types and constants for the polynomial evaluator sequencer.
// Holds the sequencer state encoding, operand slot indices, the data width
// and the default handshake timing used by the evaluator on the board.
package poly_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;
  localparam logic [1:0] OP_X = 2'd3;

  localparam int DEF_GO_CYCLES    = 2;
  localparam int DEF_GAP_CYCLES   = 2;
  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_RESULT_LAT   = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_WAIT_RES,
    S_PRESENT,
    S_FINISH
  } seq_state_e;

  // The evaluator expects operands in the fixed order A, B, C, X.
  function automatic logic [DATA_W-1:0] select_operand(
    input logic [1:0]        idx,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] x
  );
    logic [DATA_W-1:0] val;
    case (idx)
      OP_A:    val = a;
      OP_B:    val = b;
      OP_C:    val = c;
      default: val = x;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/poly_ref_model.sv
// Combinational reference for y = a + b*x + c*x*x, all arithmetic mod 256.
// Used only by the optional result checker inside the sequencer.
module poly_ref_model
  import poly_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  input  logic [DATA_W-1:0] x_i,
  output logic [DATA_W-1:0] y_o
);

  logic [DATA_W-1:0] x_sq;

  // Truncating every product to the data width gives the mod-256 result.
  always_comb begin
    x_sq = x_i * x_i;
    y_o  = a_i + (b_i * x_i) + (c_i * x_sq);
  end

endmodule

// File: rtl/poly_eval_sequencer.sv
// Drives the polynomial evaluator's go/data_in operand-load protocol for a
// sweep of x values and returns (x, y) pairs on a valid/ready interface.
// Optional result checker: define POLY_SEQ_CHECK_EN to compare every captured
// result against poly_ref_model and raise the sticky mismatch flag.
module poly_eval_sequencer
  import poly_pkg::*;
#(
  parameter int GO_CYCLES    = DEF_GO_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int RESULT_LAT   = DEF_RESULT_LAT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] coef_a,
  input  logic [DATA_W-1:0] coef_b,
  input  logic [DATA_W-1:0] coef_c,
  input  logic [DATA_W-1:0] x_start,
  input  logic [DATA_W-1:0] x_step,
  input  logic [DATA_W-1:0] x_count,
  input  logic [DATA_W-1:0] eval_result,
  output logic              go,
  output logic [DATA_W-1:0] data_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_x,
  output logic [DATA_W-1:0] res_y,
  output logic              busy,
  output logic              done,
  output logic              mismatch
);

  // The result latency is counted from the first GAP cycle of X, so the
  // GAP cycles already spent are subtracted from the WAIT_RES dwell.
  localparam int WAIT_CYCLES = (RESULT_LAT > GAP_CYCLES) ? (RESULT_LAT - GAP_CYCLES) : 1;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] GO_LAST    = 8'(GO_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(WAIT_CYCLES - 1);

  seq_state_e        state_q;
  logic [7:0]        cnt_q;
  logic [1:0]        op_idx_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] step_q;
  logic [DATA_W-1:0] remain_q;
  logic              go_q;
  logic [DATA_W-1:0] data_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_x_q;
  logic [DATA_W-1:0] res_y_q;
  logic              busy_q;
  logic              done_q;

  logic [1:0]        next_idx_d;
  logic [DATA_W-1:0] next_operand_d;
  logic              capture_d;

  // Next operand to present once the current operand's GAP has elapsed.
  always_comb begin
    next_idx_d     = op_idx_q + 2'd1;
    next_operand_d = select_operand(next_idx_d, a_q, b_q, c_q, x_q);
    capture_d      = (state_q == S_WAIT_RES) && (cnt_q == WAIT_LAST);
  end

  // Sweep sequencer: operand loading, result capture, handshake and finish.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_idx_q    <= OP_A;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      x_q         <= '0;
      step_q      <= '0;
      remain_q    <= '0;
      go_q        <= 1'b0;
      data_q      <= '0;
      res_valid_q <= 1'b0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q      <= coef_a;
            b_q      <= coef_b;
            c_q      <= coef_c;
            x_q      <= x_start;
            step_q   <= x_step;
            remain_q <= x_count;
            if (x_count == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q   <= 1'b1;
              op_idx_q <= OP_A;
              cnt_q    <= '0;
              data_q   <= coef_a;
              state_q  <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= '0;
            go_q    <= 1'b1;
            state_q <= S_PULSE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_PULSE: begin
          if (cnt_q == GO_LAST) begin
            cnt_q   <= '0;
            go_q    <= 1'b0;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (op_idx_q == OP_X) begin
              state_q <= S_WAIT_RES;
            end else begin
              op_idx_q <= next_idx_d;
              data_q   <= next_operand_d;
              state_q  <= S_SETUP;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WAIT_RES: begin
          if (capture_d) begin
            cnt_q       <= '0;
            res_y_q     <= eval_result;
            res_x_q     <= x_q;
            res_valid_q <= 1'b1;
            state_q     <= S_PRESENT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_PRESENT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            x_q         <= x_q + step_q;
            remain_q    <= remain_q - 8'd1;
            if (remain_q == 8'd1) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              op_idx_q <= OP_A;
              data_q   <= a_q;
              state_q  <= S_SETUP;
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign go        = go_q;
  assign data_out  = data_q;
  assign res_valid = res_valid_q;
  assign res_x     = res_x_q;
  assign res_y     = res_y_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef POLY_SEQ_CHECK_EN
  logic [DATA_W-1:0] model_y;
  logic              mismatch_q;

  poly_ref_model u_ref_model (
    .a_i (a_q),
    .b_i (b_q),
    .c_i (c_q),
    .x_i (x_q),
    .y_o (model_y)
  );

  // Sticky flag set whenever a captured result disagrees with the model.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mismatch_q <= 1'b0;
    end else if (capture_d && (model_y != eval_result)) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_poly_eval_sequencer.sv
// Directed bench for poly_eval_sequencer with a behavioural evaluator that
// latches operands on go pulses and computes a + b*x + c*x*x mod 256.
module tb_poly_eval_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] coef_a, coef_b, coef_c;
  logic [7:0] x_start, x_step, x_count;
  logic [7:0] eval_result;
  logic       go;
  logic [7:0] data_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_x, res_y;
  logic       busy, done, mismatch;

  int checks   = 0;
  int failures = 0;

  poly_eval_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .coef_a      (coef_a),
    .coef_b      (coef_b),
    .coef_c      (coef_c),
    .x_start     (x_start),
    .x_step      (x_step),
    .x_count     (x_count),
    .eval_result (eval_result),
    .go          (go),
    .data_out    (data_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_x       (res_x),
    .res_y       (res_y),
    .busy        (busy),
    .done        (done),
    .mismatch    (mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural evaluator: latch operand on go rising, advance slot on go falling.
  logic [7:0] ev_op [4];
  logic [1:0] ev_idx;
  logic       ev_go_prev;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ev_idx     <= 2'd0;
      ev_go_prev <= 1'b0;
      for (int i = 0; i < 4; i++) ev_op[i] <= 8'd0;
    end else begin
      ev_go_prev <= go;
      if (go && !ev_go_prev) ev_op[ev_idx] <= data_out;
      if (!go && ev_go_prev) ev_idx <= ev_idx + 2'd1;
    end
  end

  assign eval_result = ev_op[0] + ev_op[1] * ev_op[3] + ev_op[2] * ev_op[3] * ev_op[3];

  // Protocol monitor: logs operand values, pulse widths, low gaps and latency.
  int         cyc = 0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  logic       mon_go_prev = 1'b0;
  logic       mon_valid_prev = 1'b0;
  logic [7:0] rise_data [$];
  int         widths [$];
  int         gaps [$];
  int         lats [$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (go && !mon_go_prev) begin
      rise_data.push_back(data_out);
      gaps.push_back(cyc - fall_cyc);
      rise_cyc = cyc;
    end
    if (!go && mon_go_prev) begin
      widths.push_back(cyc - rise_cyc);
      fall_cyc = cyc;
    end
    if (res_valid && !mon_valid_prev) lats.push_back(cyc - fall_cyc);
    mon_go_prev    = go;
    mon_valid_prev = res_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                               input logic [7:0] xs, input logic [7:0] st, input logic [7:0] n);
    @(negedge clk);
    coef_a  = a;
    coef_b  = b;
    coef_c  = c;
    x_start = xs;
    x_step  = st;
    x_count = n;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(res_valid), 32'd1);
  endtask

  int  base_r, base_w, base_l;
  int  stall_bad;
  logic found;

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    coef_a    = 8'd0;
    coef_b    = 8'd0;
    coef_c    = 8'd0;
    x_start   = 8'd0;
    x_step    = 8'd0;
    x_count   = 8'd0;
    res_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_go", 32'(go), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_valid_busy_done", 32'({res_valid, busy, done}), 32'd0);
    checkOutput("rst_res_xy", 32'({res_x, res_y}), 32'd0);
    checkOutput("rst_mismatch", 32'(mismatch), 32'd0);
    resetn = 1'b1;

    // count = 0: done next cycle, evaluator untouched
    base_r = rise_data.size();
    applyStimulus(8'd5, 8'd6, 8'd7, 8'd1, 8'd1, 8'd0);
    checkOutput("cnt0_done", 32'(done), 32'd1);
    checkOutput("cnt0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("cnt0_done_drop", 32'(done), 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("cnt0_no_go", 32'(rise_data.size() - base_r), 32'd0);

    // Single point: a=1 b=2 c=3 x=2 -> 17
    base_r = rise_data.size();
    base_w = widths.size();
    base_l = lats.size();
    applyStimulus(8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd1);
    checkOutput("sp_busy", 32'(busy), 32'd1);
    waitValid("sp_valid");
    checkOutput("sp_res_x", 32'(res_x), 32'd2);
    checkOutput("sp_res_y", 32'(res_y), 32'd17);
    @(negedge clk);
    checkOutput("sp_valid_drop", 32'(res_valid), 32'd0);
    checkOutput("sp_done", 32'(done), 32'd1);
    checkOutput("sp_busy_drop", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("sp_done_drop", 32'(done), 32'd0);
    checkOutput("sp_pulses", 32'(rise_data.size() - base_r), 32'd4);
    checkOutput("sp_op_a", 32'(rise_data[base_r]), 32'd1);
    checkOutput("sp_op_b", 32'(rise_data[base_r + 1]), 32'd2);
    checkOutput("sp_op_c", 32'(rise_data[base_r + 2]), 32'd3);
    checkOutput("sp_op_x", 32'(rise_data[base_r + 3]), 32'd2);
    for (int i = 0; i < 4; i++) checkOutput("sp_go_width", 32'(widths[base_w + i]), 32'd2);
    for (int i = 1; i < 4; i++) checkOutput("sp_go_low_gap", 32'(gaps[base_r + i]), 32'd3);
    checkOutput("sp_latency", 32'(lats[base_l]), 32'd6);
    checkOutput("sp_mismatch", 32'(mismatch), 32'd0);

    // Sweep a=b=c=1 x=0,1,2 -> 1,3,7, with a start issued while busy
    applyStimulus(8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd3);
    waitValid("sw_valid0");
    checkOutput("sw_x0", 32'(res_x), 32'd0);
    checkOutput("sw_y0", 32'(res_y), 32'd1);
    applyStimulus(8'd9, 8'd9, 8'd9, 8'd100, 8'd5, 8'd1);
    checkOutput("sw_busy_ignore", 32'(busy), 32'd1);
    waitValid("sw_valid1");
    checkOutput("sw_x1", 32'(res_x), 32'd1);
    checkOutput("sw_y1", 32'(res_y), 32'd3);
    @(negedge clk);
    waitValid("sw_valid2");
    checkOutput("sw_x2", 32'(res_x), 32'd2);
    checkOutput("sw_y2", 32'(res_y), 32'd7);
    @(negedge clk);
    checkOutput("sw_done", 32'(done), 32'd1);
    repeat (8) @(negedge clk);
    checkOutput("sw_idle_after", 32'({busy, go}), 32'd0);

    // Wrap: x = 250, 253, 0 -> y = 31, 7, 1
    applyStimulus(8'd1, 8'd1, 8'd1, 8'd250, 8'd3, 8'd3);
    waitValid("wr_valid0");
    checkOutput("wr_x0", 32'(res_x), 32'd250);
    checkOutput("wr_y0", 32'(res_y), 32'd31);
    @(negedge clk);
    waitValid("wr_valid1");
    checkOutput("wr_x1", 32'(res_x), 32'd253);
    checkOutput("wr_y1", 32'(res_y), 32'd7);
    @(negedge clk);
    waitValid("wr_valid2");
    checkOutput("wr_x2", 32'(res_x), 32'd0);
    checkOutput("wr_y2", 32'(res_y), 32'd1);
    @(negedge clk);
    checkOutput("wr_done", 32'(done), 32'd1);

    // Backpressure: a=2 b=0 c=1, x=3 then 5 -> 11, 27
    res_ready = 1'b0;
    applyStimulus(8'd2, 8'd0, 8'd1, 8'd3, 8'd2, 8'd2);
    waitValid("bp_valid0");
    checkOutput("bp_x0", 32'(res_x), 32'd3);
    checkOutput("bp_y0", 32'(res_y), 32'd11);
    base_r    = rise_data.size();
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_x !== 8'd3 || res_y !== 8'd11 || go !== 1'b0) stall_bad++;
    end
    checkOutput("bp_stable", 32'(stall_bad), 32'd0);
    checkOutput("bp_no_go", 32'(rise_data.size() - base_r), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_valid_drop", 32'(res_valid), 32'd0);
    waitValid("bp_valid1");
    checkOutput("bp_x1", 32'(res_x), 32'd5);
    checkOutput("bp_y1", 32'(res_y), 32'd27);
    @(negedge clk);
    checkOutput("bp_done", 32'(done), 32'd1);

    // Reset during the C pulse, then a fresh sweep reloads from A
    applyStimulus(8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd2);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (go === 1'b1 && data_out === 8'd3) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("mr_found_c_pulse", 32'(found), 32'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("mr_go", 32'(go), 32'd0);
    checkOutput("mr_data_out", 32'(data_out), 32'd0);
    checkOutput("mr_valid_busy_done", 32'({res_valid, busy, done}), 32'd0);
    checkOutput("mr_res_xy", 32'({res_x, res_y}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    base_r = rise_data.size();
    applyStimulus(8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd1);
    waitValid("mr_valid");
    checkOutput("mr_res_x", 32'(res_x), 32'd2);
    checkOutput("mr_res_y", 32'(res_y), 32'd17);
    checkOutput("mr_op_a", 32'(rise_data[base_r]), 32'd1);
    checkOutput("mr_op_x", 32'(rise_data[base_r + 3]), 32'd2);
    @(negedge clk);
    checkOutput("mr_done", 32'(done), 32'd1);
    checkOutput("mr_mismatch", 32'(mismatch), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_eval_sequencer.md
Name: poly_eval_sequencer

Overview:
- Initiator for the polynomial evaluator's go/data_in operand-load protocol.
- Takes coefficients A, B, C and an x sweep (start, step, count), then drives go and data_in to load A, B, C, X in that order.
- For each point, waits the evaluator's fixed compute latency, captures data_result, and returns (x, y) pairs on a valid/ready output.
- Sits between the board's switch/key logic (or a test harness) and the evaluator, replacing manual KEY/SW sequencing.

Parameters:
- GO_CYCLES, 2: cycles go is held high per operand (min 1).
- GAP_CYCLES, 2: cycles go is held low after each pulse, data_out held stable (min 1).
- SETUP_CYCLES, 1: cycles data_out is stable before go rises (min 1).
- RESULT_LAT, 6: cycles from go falling for X until data_result is valid.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sweep; ignored while busy
- coef_a, coef_b, coef_c  in  8 each  coefficients, sampled on accepted start
- x_start  in  8  first x, sampled on accepted start
- x_step  in  8  x increment, sampled on accepted start
- x_count  in  8  number of points, sampled on accepted start
- eval_result  in  8  evaluator data_result
- go  out  1  evaluator go
- data_out  out  8  evaluator data_in
- res_valid  out  1  result pair available
- res_ready  in  1  consumer accepts pair when res_valid && res_ready
- res_x  out  8  x for the presented result
- res_y  out  8  captured eval_result
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep completes
- mismatch  out  1  sticky checker flag (see Optional Feature)

Behaviour:
- Reset (async, resetn=0): state IDLE. go, data_out, res_valid, res_x, res_y, busy, done, mismatch all 0. Evaluator shares resetn, so both sides restart at operand A.
- Start acceptance:
  - Start in IDLE latches all inputs.
  - x_count=0: done pulses the next cycle and state stays IDLE; evaluator untouched.
  - Otherwise busy=1 from the next cycle until done.
- States: IDLE -> SETUP -> PULSE -> GAP, repeated per operand (index 0..3 = A, B, C, X) -> WAIT_RES -> PRESENT -> next point or FINISH -> IDLE.
  - SETUP: data_out=operand, go=0, SETUP_CYCLES cycles.
  - PULSE: go=1, GO_CYCLES cycles.
  - GAP: go=0, data_out held, GAP_CYCLES cycles. Then next operand, or WAIT_RES after X.
  - WAIT_RES: RESULT_LAT cycles counted from the first GAP cycle of X. On exit, res_y<=eval_result, res_x<=current x.
  - PRESENT: res_valid=1. res_x and res_y are stable until the handshake.
  - On handshake: x<=x+x_step (mod 256), remaining count decremented. Then SETUP for A if points remain, else FINISH.
  - FINISH: done=1 for one cycle, busy=0.
- Every point reloads all four operands, because the evaluator returns to its A-load state after computing.
- go is never high in consecutive operand slots without at least GAP_CYCLES low between them.
- Backpressure: the evaluator idles in its A-load state while PRESENT stalls. No timeout.
- Arithmetic: x wraps modulo 256; 8-bit counters; remaining count is 8-bit unsigned.
- Simultaneous events: start during busy is ignored. A handshake on the final point and done occur in consecutive cycles, never the same cycle.
- Mid-operation reset: all outputs return to reset values immediately, with no partial result presented.

Optional Feature:
- Macro POLY_SEQ_CHECK_EN.
- Defined:
  - An internal model computes (coef_a + coef_b*x + coef_c*x*x) mod 256 at capture.
  - mismatch is set if the model disagrees with eval_result and stays set until reset.
  - Checking is timing-neutral.
- Undefined: model absent, mismatch tied 0.

Decomposition:
- Package poly_pkg holds:
  - Sequencer state encoding.
  - Operand index constants (OP_A=0, OP_B=1, OP_C=2, OP_X=3).
  - Data width constant 8.
  - Default timing constants.
- One sub-module, poly_ref_model: combinational reference polynomial, instantiated only under POLY_SEQ_CHECK_EN.

Test Plan:
- Single point: a=1, b=2, c=3, x_start=2, count=1, ideal evaluator model -> go pulses 4 times, data_out=1,2,3,2 in order, res_x=2, res_y=17, done one cycle after the handshake, mismatch=0.
- Sweep: a=b=c=1, x_start=0, step=1, count=3, res_ready=1 -> res_y=1,3,7 with res_x=0,1,2.
- Wrap: x_start=250, step=3, count=3 -> res_x=250,253,0.
- Backpressure: res_ready=0 for 20 cycles on point 1 -> res_valid, res_x, res_y stable, go=0 throughout, then the sweep resumes.
- Boundaries:
  - count=0 -> done next cycle, go never asserted.
  - Start while busy -> ignored.
- Reset mid-sweep in PULSE of C -> all outputs 0 at once. A new start reloads from A, and its first result is correct.
